debounce_sync_edge: RTL and testbench
=====================================

# debounce_sync_edge

Input-conditioning stage that sits directly upstream of the team's D/T/JK flip-flop and latch cells. It takes one raw asynchronous level (push-button, switch or external strobe) and passes it through a flip-flop synchronizer chain. It then debounces the level with a counter-qualified state machine and delivers a clean registered level plus one-cycle rise/fall pulses, suitable as `d`, `t` or clock-enable inputs to downstream flip-flops.

## Interface
- `SYNC_STAGES`, 2: synchronizer flip-flop count; legal range 2..4.
- `CNT_W`, 16: debounce counter width.
- `DEBOUNCE_CYCLES`, 1000: consecutive enabled cycles a new level must hold; legal range 1 ≤ value ≤ 2**CNT_W, otherwise elaboration error.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  1  raw asynchronous input.
- `en`  in  1  count-enable tick (tie high for per-cycle counting).
- `q`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle pulse when `q` goes 0→1.
- `fall`  out  1  one-cycle pulse when `q` goes 1→0.
- `busy`  out  1  high while a candidate transition is being qualified.

## Operation
- Reset values: sync chain all 0, state IDLE_LO, counter 0, `q`=0, `rise`=0, `fall`=0, `busy`=0.
- `s` = last sync-stage output. Only `s` is used by the FSM; `din` is never used directly.
- IDLE_LO:
  - `s`=1 → WAIT_HI, counter←0.
  - Else stay.
- WAIT_HI:
  - `s`=0 → IDLE_LO, counter←0. The bounce aborts qualification regardless of `en`.
  - Else, if `en`=1 and counter=`DEBOUNCE_CYCLES`-1 → IDLE_HI, `q`←1, `rise`←1.
  - Else, if `en`=1 → counter+1.
  - `en`=0 with `s`=1 → hold the counter.
- IDLE_HI and WAIT_LO mirror the above with polarity swapped; qualification ends with `q`←0 and `fall`←1.
- `rise` and `fall` are registered and high for exactly one cycle, coincident with the `q` change. They are never both high.
- `busy` is decoded from the state register: 1 in WAIT_HI or WAIT_LO.
- Counter never wraps; it cannot exceed `DEBOUNCE_CYCLES`-1.
- `DEBOUNCE_CYCLES`=1: the transition occurs on the first enabled edge spent in WAIT.

## Timing
- Definition: `din` changes and is set up before edge E0.
- The new value is on `s` after edge E0+`SYNC_STAGES`-1.
- The FSM enters WAIT at edge E0+`SYNC_STAGES`.
- With `en`=1, `q`, `rise` and `fall` update at edge E0+`SYNC_STAGES`+`DEBOUNCE_CYCLES`.
- With `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4, latency is 6 edges.
- Entering WAIT does not require `en`. Each later edge in WAIT consumes one count only if `en`=1.
- Asserting `rst` at any time, including mid-WAIT or the cycle of a pulse:
  - Outputs go to reset values immediately, without waiting for `clk`.
  - Any pending pulse is discarded.
- After `rst` deasserts, the first rising edge samples `din` into stage 1. If `din` is 1 at release, a normal rise qualification follows: `rise` fires `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges after that first edge.
- A `din` pulse shorter than one cycle may or may not be captured. Either way it cannot change `q` unless it satisfies the qualification rule above.

## Structure
- Shared package/header `debounce_pkg` holds:
  - 2-bit state encodings: IDLE_LO=00, WAIT_HI=01, IDLE_HI=10, WAIT_LO=11.
  - The parameter-range check macro.
- Sub-module `sync_ff_chain` (parameter `STAGES`; ports `clk`, `rst`, `d`, `q`), built from flip-flops with asynchronous reset to 0. The top level instantiates it once.
- The FSM, counter and output registers live in `debounce_sync_edge`.

## Test plan
Configuration for all scenarios: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `en`=1 unless stated.
- Reset check: `rst`=1 with `din`=1 → `q`=0, `rise`=0, `fall`=0, `busy`=0. After release, `rise`=1 exactly at the 6th edge, `q`=1 from then on, and `rise`=0 on the 7th edge.
- Clean rise and fall from `q`=0:
  - Hold `din`=1 → `busy` rises at edge 2, `rise` and `q`=1 at edge 6.
  - Then hold `din`=0 → `fall` at edge 6 and `q`=0.
- Bounce rejection: `din`=1 for 3 cycles, then 0 → `busy` goes 1 then 0, `q` stays 0, no `rise`. Repeat the pattern 10 times with no change on `q`.
- `en` gating: `din`→1 held, with `en` high only on odd edges E0+3, 5, 7, 9 → `q`=1 and `rise` at edge E0+9, not earlier.
- Reset mid-WAIT: with `din`=1 and the counter at 2, pulse `rst` → `q`=0 and `busy`=0 without a `clk` edge, and no `rise` during reset. After release with `din` still 1, `rise` occurs 6 edges later.
- Single-cycle glitch: `din` at 0→1→0 lasting one cycle → `busy` high for at most one cycle, `q`, `rise` and `fall` unchanged.

Source files
------------

// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the input-conditioning stage.
//   state_e             : 2-bit debounce FSM state encoding
//   debounceParamsLegal : elaboration-time parameter range check
// ---------------------------------------------------------------------------
package debounce_pkg;

    // The upper bit holds the stable level the FSM is resting at or leaving,
    // and the lower bit marks "currently qualifying a new level".
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } state_e;

    // True when the synchronizer depth, counter width and debounce length
    // form a usable combination. The debounce length may equal 2**CNT_W
    // because the counter only ever has to reach DEBOUNCE_CYCLES-1.
    function automatic bit debounceParamsLegal(input int syncStages,
                                               input int cntW,
                                               input int cycles);
        longint maxCycles;
        maxCycles = longint'(1) << cntW;
        return (syncStages >= 2) && (syncStages <= 4) &&
               (cntW >= 1) && (cntW <= 31) &&
               (cycles >= 1) && (longint'(cycles) <= maxCycles);
    endfunction

endpackage

`ifndef DEBOUNCE_CHECK_PARAMS
`define DEBOUNCE_CHECK_PARAMS(SS, CW, DC) \
    if (!debounce_pkg::debounceParamsLegal((SS), (CW), (DC))) begin : gBadParams \
        $error("debounce_sync_edge: illegal SYNC_STAGES/CNT_W/DEBOUNCE_CYCLES"); \
    end
`endif

// File: rtl/debounce_sync_edge_sync_ff_chain.sv
// ---------------------------------------------------------------------------
// sync_ff_chain
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : raw asynchronous input
//   q   : synchronized level (output of the last stage)
// ---------------------------------------------------------------------------
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;

    // Plain shift register: stage 0 takes the raw input, each later stage
    // gives the previous one a full cycle to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    // Only the final stage is safe to consume downstream.
    always_comb begin
        q = stage_q[STAGES-1];
    end

endmodule

// File: rtl/debounce_sync_edge.sv
// ---------------------------------------------------------------------------
// debounce_sync_edge
// Synchronizes a raw asynchronous level, debounces it with a counter-
// qualified FSM and produces a clean registered level plus edge pulses.
//   clk  : single clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   din  : raw asynchronous input
//   en   : count-enable tick (tie high to count every cycle)
//   q    : debounced level, registered
//   rise : one-cycle pulse coincident with q going 0->1
//   fall : one-cycle pulse coincident with q going 1->0
//   busy : high while a candidate transition is being qualified
// ---------------------------------------------------------------------------
module debounce_sync_edge
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Refuse to elaborate with a debounce length the counter cannot express
    // or a synchronizer depth outside the supported range.
    if (!debounceParamsLegal(SYNC_STAGES, CNT_W, DEBOUNCE_CYCLES)) begin : gBadParams
        $error("debounce_sync_edge: illegal SYNC_STAGES/CNT_W/DEBOUNCE_CYCLES");
    end

    // Terminal count: the qualifying edge is the one that sees this value.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncLevel;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (syncLevel)
    );

    // State register. The level and pulse registers live here too so that
    // q, rise and fall all change on the same edge as the state, and an
    // asynchronous reset wipes any pulse that was about to be presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic. Entering a WAIT state is unconditional on en; every
    // later edge in WAIT consumes a count only when en is high. A bounce
    // back to the current level abandons the qualification immediately.
    // The counter is cleared on every exit from WAIT, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE_LO: begin
                if (syncLevel) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!syncLevel) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            IDLE_HI: begin
                if (!syncLevel) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (syncLevel) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode. busy comes straight from the state register so it is
    // glitch-free; the rest are the registered values.
    always_comb begin
        busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);
        q    = level_q;
        rise = rise_q;
        fall = fall_q;
    end

endmodule

// File: tb/tb_debounce_sync_edge.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync_edge
// Scoreboard bench for debounce_sync_edge with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. A history-based reference model predicts each edge's
// outputs; a separate monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_debounce_sync_edge;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } outs_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic din  = 1'b0;
    logic en   = 1'b1;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int checks   = 0;
    int failures = 0;

    outs_t expQ[$];
    string nameQ[$];

    // Reference model history, indexed by edge number since reset release.
    logic dinHist[$];
    logic enHist[$];
    logic sHist[$];
    logic qModel = 1'b0;

    debounce_sync_edge #(
        .SYNC_STAGES     (SYNC),
        .CNT_W           (16),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed output set against the expected one.
    task automatic checkOutput(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got q=%0b rise=%0b fall=%0b busy=%0b, expected q=%0b rise=%0b fall=%0b busy=%0b",
                     name, got.q, got.rise, got.fall, got.busy,
                     exp.q, exp.rise, exp.fall, exp.busy);
        end
    endtask

    // Drive din/en for the next rising edge and push the predicted result.
    // Model: the synchronized value seen at edge k is din from edge k-SYNC.
    // If that differs from the current level, find where the current run of
    // differing values began; q flips once DEB enabled edges have elapsed
    // strictly after that starting edge.
    task automatic applyStimulus(input logic d, input logic e, input string tag);
        int    k;
        int    j;
        int    cnt;
        logic  sk;
        outs_t x;
        @(negedge clk);
        din = d;
        en  = e;
        k = dinHist.size();
        dinHist.push_back(d);
        enHist.push_back(e);
        sk = (k >= SYNC) ? dinHist[k-SYNC] : 1'b0;
        sHist.push_back(sk);
        x = '0;
        if (sk !== qModel) begin
            j = k;
            while (j > 0 && sHist[j-1] !== qModel) j--;
            cnt = 0;
            for (int i = j + 1; i <= k; i++) begin
                if (enHist[i]) cnt++;
            end
            if (cnt == DEB) begin
                qModel = sk;
                x.rise = sk;
                x.fall = ~sk;
            end
        end
        x.q    = qModel;
        x.busy = (sk !== qModel);
        expQ.push_back(x);
        nameQ.push_back($sformatf("%s#%0d", tag, k));
    endtask

    // Assert reset between clock edges and confirm outputs clear without an
    // edge, stay clear while held, then release just after a rising edge so
    // the next rising edge is the first one to sample din.
    task automatic resetDut(input logic dinDuring, input string tag);
        @(negedge clk);
        din = dinDuring;
        #1 rst = 1'b1;
        #1 checkOutput({tag, "_async"}, {q, rise, fall, busy}, outs_t'('0));
        repeat (3) begin
            @(negedge clk);
            checkOutput({tag, "_hold"}, {q, rise, fall, busy}, outs_t'('0));
        end
        @(posedge clk);
        #2 rst = 1'b0;
        dinHist.delete();
        enHist.delete();
        sHist.delete();
        qModel = 1'b0;
    endtask

    // Monitor: every rising edge, one cycle's expected outputs are compared.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(nameQ.pop_front(), {q, rise, fall, busy}, expQ.pop_front());
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int len;
        logic d;

        // Reset with din high, then a normal rise qualification follows.
        resetDut(1'b1, "rst");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, "rstRise");

        // Clean fall, then clean rise and fall again.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, "cleanFall");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, "cleanRise");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, "cleanFall2");

        // Bounce rejection: three high cycles never qualify.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "bounceHi");
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "bounceLo");
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, "settle");

        // en gating: enabled only on E0+3, 5, 7, 9.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, (i == 3 || i == 5 || i == 7 || i == 9), "enGate");
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, "enGateFall");

        // Reset mid-WAIT with the counter at 2, then requalify from scratch.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, "midWait");
        resetDut(1'b1, "midRst");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, "postRst");

        // Single-cycle glitches in both directions.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, "preGlitchHi");
        applyStimulus(1'b0, 1'b1, "glitchLo");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, "postGlitchHi");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, "toLow");
        applyStimulus(1'b1, 1'b1, "glitchHi");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, "postGlitchLo");

        // Randomized runs of random length with a mostly-high enable.
        for (int r = 0; r < 60; r++) begin
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                applyStimulus(d, ($urandom_range(0, 3) != 0), "rand");
            end
        end

        // Drain the last expectation before reporting.
        @(posedge clk);
        #3;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
